// File: rtl/sd_fifo_sched.sv
// SD-clock-side round-robin access scheduler for the 4-channel shared-DPRAM SD FIFO.
// Per-channel access counters are built only when SD_FIFO_SCHED_STAT_EN is defined.
module sd_fifo_sched #(
    parameter int BURST = 4,
    parameter int DW    = 8
) (
    input  logic          sd_clk,
    input  logic          rst,
    input  logic [4:1]    fifo_full,
    input  logic [4:1]    fifo_empty,
    output logic [1:0]    sd_adr_o,
    output logic          sd_re_o,
    output logic          sd_we_o,
    output logic [DW-1:0] sd_dat_o,
    input  logic [DW-1:0] sd_dat_i,
    output logic [DW-1:0] tx1_data,
    output logic          tx1_valid,
    input  logic          tx1_ready,
    output logic [DW-1:0] tx3_data,
    output logic          tx3_valid,
    input  logic          tx3_ready,
    input  logic [DW-1:0] rx2_data,
    input  logic          rx2_valid,
    output logic          rx2_ready,
    input  logic [DW-1:0] rx4_data,
    input  logic          rx4_valid,
    output logic          rx4_ready,
    output logic [63:0]   stat_cnt,
    output logic          o_dbg_state
);
    // Handshake: a stream beat moves on any cycle with valid & ready both high. tx*_valid and
    // tx*_data hold until taken; rx*_ready is high only in the cycle the FIFO write is issued.

    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;
    localparam logic [3:0] LP_BURST = 4'(BURST);

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_ptr, w_ptr_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic          w_gnt;
    logic [1:0]    w_gch;
    logic [3:0]    w_req;

    // Index 0 is channel 1, index 1 is channel 3.
    logic [DW-1:0] r_buf [2][2];
    logic [1:0]    r_occ [2];
    logic [1:0]    r_infl;
    logic [1:0]    w_tx_rdy;
    logic [1:0]    w_tx_vld;
    logic [1:0]    w_pop;
    logic [1:0]    w_room;
    logic [DW-1:0] w_tx_dat [2];
    logic [2:0]    w_level [2];

    // Read data is forwarded straight from sd_dat_i while the buffer is empty, so a beat
    // reaches the stream in the cycle after its read strobe.
    always_comb begin
        w_tx_rdy = {tx3_ready, tx1_ready};
        for (int t = 0; t < 2; t++) begin
            w_tx_vld[t] = (r_occ[t] != 2'd0) || r_infl[t];
            w_tx_dat[t] = (r_occ[t] != 2'd0) ? r_buf[t][0] : sd_dat_i;
            w_pop[t]    = w_tx_vld[t] & w_tx_rdy[t];
            w_level[t]  = {1'b0, r_occ[t]} + {2'b00, r_infl[t]} - {2'b00, w_pop[t]};
            w_room[t]   = w_level[t] < 3'd2;
        end
    end

    assign tx1_valid = w_tx_vld[0];
    assign tx1_data  = w_tx_dat[0];
    assign tx3_valid = w_tx_vld[1];
    assign tx3_data  = w_tx_dat[1];

    // Requests are gated by rst so strobes fall the instant reset asserts.
    assign w_req[0] = rst & ~fifo_empty[1] & w_room[0];
    assign w_req[1] = rst & rx2_valid & ~fifo_full[2];
    assign w_req[2] = rst & ~fifo_empty[3] & w_room[1];
    assign w_req[3] = rst & rx4_valid & ~fifo_full[4];

    function automatic logic [1:0] f_next(input logic [1:0] p, input logic [3:0] req);
        logic [1:0] c;
        f_next = p;
        for (int k = 4; k >= 1; k--) begin
            c = p + 2'(k);
            if (req[c]) f_next = c;
        end
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt       = 1'b0;
        w_gch       = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_gnt       = 1'b1;
                    w_gch       = f_next(r_ptr, w_req);
                    w_state_nxt = S_GRANT;
                    w_cnt_nxt   = 4'd1;
                    w_ptr_nxt   = w_gch;
                end
            end
            S_GRANT: begin
                if (w_req[r_ptr] && (r_cnt < LP_BURST)) begin
                    w_gnt     = 1'b1;
                    w_gch     = r_ptr;
                    w_cnt_nxt = r_cnt + 4'd1;
                end else if (|w_req) begin
                    w_gnt     = 1'b1;
                    w_gch     = f_next(r_ptr, w_req);
                    w_cnt_nxt = 4'd1;
                    w_ptr_nxt = w_gch;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Odd channels (1, 3) are reads, even channels (2, 4) are writes.
    assign sd_adr_o  = w_gnt ? w_gch : 2'd0;
    assign sd_re_o   = w_gnt & ~w_gch[0];
    assign sd_we_o   = w_gnt & w_gch[0];
    assign sd_dat_o  = sd_we_o ? (w_gch[1] ? rx4_data : rx2_data) : '0;
    assign rx2_ready = w_gnt & (w_gch == 2'd1);
    assign rx4_ready = w_gnt & (w_gch == 2'd3);
    assign o_dbg_state = r_state;

    always_ff @(posedge sd_clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd3;
            r_cnt   <= 4'd0;
            r_infl  <= 2'b00;
            for (int t = 0; t < 2; t++) begin
                r_occ[t]    <= 2'd0;
                r_buf[t][0] <= '0;
                r_buf[t][1] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_infl[0] <= w_gnt & (w_gch == 2'd0);
            r_infl[1] <= w_gnt & (w_gch == 2'd2);
            for (int t = 0; t < 2; t++) begin
                case ({r_infl[t], w_pop[t]})
                    2'b10: begin
                        if (r_occ[t] == 2'd0) r_buf[t][0] <= sd_dat_i;
                        else                  r_buf[t][1] <= sd_dat_i;
                        r_occ[t] <= r_occ[t] + 2'd1;
                    end
                    2'b01: begin
                        r_buf[t][0] <= r_buf[t][1];
                        r_occ[t]    <= r_occ[t] - 2'd1;
                    end
                    2'b11: begin
                        // Pop and fill together: occupancy stays, new byte goes behind the head.
                        if (r_occ[t] == 2'd1) begin
                            r_buf[t][0] <= sd_dat_i;
                        end else if (r_occ[t] == 2'd2) begin
                            r_buf[t][0] <= r_buf[t][1];
                            r_buf[t][1] <= sd_dat_i;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SD_FIFO_SCHED_STAT_EN
    logic [15:0] r_stat [4];

    always_ff @(posedge sd_clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++) r_stat[c] <= 16'd0;
        end else if (w_gnt) begin
            r_stat[w_gch] <= r_stat[w_gch] + 16'd1;
        end
    end

    assign stat_cnt = {r_stat[3], r_stat[2], r_stat[1], r_stat[0]};
`else
    assign stat_cnt = 64'd0;
`endif

    logic w_unused;
    assign w_unused = ^{fifo_full[1], fifo_full[3], fifo_empty[2], fifo_empty[4]};

endmodule

// File: tb/tb_sd_fifo_sched.sv
// Self-checking bench for sd_fifo_sched: emulates the four FIFOs and the stream endpoints,
// scoreboards stream/FIFO data in order and checks the round-robin burst schedule.
module tb_sd_fifo_sched;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic          sd_clk = 1'b0;
    logic          rst;
    logic [4:1]    fifo_full, fifo_empty;
    logic [1:0]    sd_adr_o;
    logic          sd_re_o, sd_we_o;
    logic [DW-1:0] sd_dat_o, sd_dat_i;
    logic [DW-1:0] tx1_data, tx3_data, rx2_data, rx4_data;
    logic          tx1_valid, tx1_ready, tx3_valid, tx3_ready;
    logic          rx2_valid, rx2_ready, rx4_valid, rx4_ready;
    logic [63:0]   stat_cnt;
    logic          o_dbg_state;

    sd_fifo_sched #(.BURST(BURST), .DW(DW)) dut (
        .sd_clk(sd_clk), .rst(rst), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .sd_adr_o(sd_adr_o), .sd_re_o(sd_re_o), .sd_we_o(sd_we_o),
        .sd_dat_o(sd_dat_o), .sd_dat_i(sd_dat_i),
        .tx1_data(tx1_data), .tx1_valid(tx1_valid), .tx1_ready(tx1_ready),
        .tx3_data(tx3_data), .tx3_valid(tx3_valid), .tx3_ready(tx3_ready),
        .rx2_data(rx2_data), .rx2_valid(rx2_valid), .rx2_ready(rx2_ready),
        .rx4_data(rx4_data), .rx4_valid(rx4_valid), .rx4_ready(rx4_ready),
        .stat_cnt(stat_cnt), .o_dbg_state(o_dbg_state)
    );

    always #5 sd_clk = ~sd_clk;

    typedef struct packed {
        logic       re;
        logic       we;
        logic [1:0] adr;
        logic [7:0] dat;
        logic       t1v;
        logic [7:0] t1d;
        logic       t3v;
        logic [7:0] t3d;
        logic       r2r;
        logic       r4r;
    } ev_t;

    ev_t           trace[$];
    logic [DW-1:0] q1[$], q3[$], src2[$], src4[$];
    logic [DW-1:0] w2[$], w4[$], got1[$], got3[$];
    logic [DW-1:0] exp_q1[$], exp_q3[$], exp_q2[$], exp_q4[$];
    logic          en2, en4, rdy1, rdy3, ovf2, ovf4;
    int            acc[4];
    int            viol;
    int            errors = 0;
    int            checks = 0;

    // ---------------- driver tasks ----------------
    task automatic drive();
        fifo_empty = {1'b1, (q3.size() == 0), 1'b1, (q1.size() == 0)};
        fifo_full  = {ovf4, 1'b0, ovf2, 1'b0};
        rx2_valid  = en2 && (src2.size() > 0);
        rx2_data   = (src2.size() > 0) ? src2[0] : 8'h00;
        rx4_valid  = en4 && (src4.size() > 0);
        rx4_data   = (src4.size() > 0) ? src4[0] : 8'h00;
        tx1_ready  = rdy1;
        tx3_ready  = rdy3;
    endtask

    // One sd_clk cycle: starts and ends at a falling edge; samples mid-low-phase and
    // acts as the FIFO memories and stream endpoints.
    task automatic tick();
        ev_t           e;
        logic [DW-1:0] nd, tmp;
        #2;
        e.re = sd_re_o; e.we = sd_we_o; e.adr = sd_adr_o; e.dat = sd_dat_o;
        e.t1v = tx1_valid; e.t1d = tx1_data; e.t3v = tx3_valid; e.t3d = tx3_data;
        e.r2r = rx2_ready; e.r4r = rx4_ready;
        trace.push_back(e);
        nd = sd_dat_i;
        if (sd_re_o && sd_we_o) viol++;
        if (tx1_valid && tx1_ready) got1.push_back(tx1_data);
        if (tx3_valid && tx3_ready) got3.push_back(tx3_data);
        if (sd_re_o) begin
            acc[sd_adr_o]++;
            if (sd_adr_o == 2'd0 && q1.size() > 0)      nd = q1.pop_front();
            else if (sd_adr_o == 2'd2 && q3.size() > 0) nd = q3.pop_front();
            else viol++;
        end
        if (sd_we_o) begin
            acc[sd_adr_o]++;
            if (sd_adr_o == 2'd1 && !fifo_full[2] && rx2_valid)      w2.push_back(sd_dat_o);
            else if (sd_adr_o == 2'd3 && !fifo_full[4] && rx4_valid) w4.push_back(sd_dat_o);
            else viol++;
        end
        if (rx2_ready !== (sd_we_o && sd_adr_o == 2'd1)) viol++;
        if (rx4_ready !== (sd_we_o && sd_adr_o == 2'd3)) viol++;
        if (rx2_valid && rx2_ready) tmp = src2.pop_front();
        if (rx4_valid && rx4_ready) tmp = src4.pop_front();
        @(negedge sd_clk);
        sd_dat_i = nd;
        drive();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; q1 = '{8'h5A}; src2 = '{8'h3C}; en2 = 1'b1; rdy1 = 1'b1;
        drive();
        #2;
        checks++; if (sd_re_o !== 1'b0) begin errors++; $display("FAIL reset_re got=%0b want=0", sd_re_o); end
        checks++; if (sd_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b want=0", sd_we_o); end
        checks++; if (sd_adr_o !== 2'd0) begin errors++; $display("FAIL reset_adr got=%0d want=0", sd_adr_o); end
        checks++; if (sd_dat_o !== 8'h00) begin errors++; $display("FAIL reset_dat got=%h want=00", sd_dat_o); end
        checks++; if ({tx1_valid, tx3_valid} !== 2'b00) begin errors++; $display("FAIL reset_txv got=%b want=00", {tx1_valid, tx3_valid}); end
        checks++; if ({rx2_ready, rx4_ready} !== 2'b00) begin errors++; $display("FAIL reset_rxr got=%b want=00", {rx2_ready, rx4_ready}); end
        checks++; if (stat_cnt !== 64'd0) begin errors++; $display("FAIL reset_stat got=%h want=0", stat_cnt); end
        q1.delete(); src2.delete(); en2 = 1'b0;
        drive();
        @(negedge sd_clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) acc[c] = 0;
        drive();
    endtask

    task automatic test_stream_read();
        int n;
        logic [DW-1:0] exp_b[3];
        exp_b = '{8'h11, 8'h22, 8'h33};
        trace.delete(); got1.delete();
        q1 = '{8'h11, 8'h22, 8'h33}; rdy1 = 1'b1;
        drive();
        repeat (8) tick();
        n = -1;
        for (int i = 0; i < trace.size(); i++) if (n < 0 && trace[i].re) n = i;
        checks++; if (n != 0) begin errors++; $display("FAIL rd_first_issue got=%0d want=0", n); end
        if (n >= 0 && n + 3 < trace.size()) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (!(trace[n+k].re && trace[n+k].adr == 2'd0)) begin errors++; $display("FAIL rd_strobe%0d got re=%0b adr=%0d want re=1 adr=0", k, trace[n+k].re, trace[n+k].adr); end
                checks++;
                if (!(trace[n+k+1].t1v && trace[n+k+1].t1d == exp_b[k])) begin errors++; $display("FAIL rd_data%0d got v=%0b d=%h want v=1 d=%h", k, trace[n+k+1].t1v, trace[n+k+1].t1d, exp_b[k]); end
            end
            checks++; if (trace[n+3].re !== 1'b0) begin errors++; $display("FAIL rd_stop got re=%0b want=0", trace[n+3].re); end
        end
        checks++; if (got1.size() != 3) begin errors++; $display("FAIL rd_count got=%0d want=3", got1.size()); end
    endtask

    task automatic test_back_to_back();
        int n, bad;
        logic [DW-1:0] b;
        logic [1:0] want;
        trace.delete(); w2.delete(); w4.delete(); exp_q2.delete(); exp_q4.delete();
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255)); src2.push_back(b); exp_q2.push_back(b);
            b = 8'($urandom_range(0, 255)); src4.push_back(b); exp_q4.push_back(b);
        end
        en2 = 1'b1; en4 = 1'b1;
        drive();
        repeat (40) tick();
        n = -1;
        for (int i = 0; i < trace.size(); i++) if (n < 0 && trace[i].we) n = i;
        checks++; if (n != 0) begin errors++; $display("FAIL b2b_first_write got=%0d want=0", n); end
        bad = 0;
        if (n >= 0) begin
            for (int i = 0; i < 32; i++) begin
                want = (((i / BURST) % 2) == 0) ? 2'd1 : 2'd3;
                if (n + i >= trace.size() || !trace[n+i].we || trace[n+i].adr != want) bad++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_schedule got=%0d bad slots want=0", bad); end
        bad = (w2.size() != 16 || w4.size() != 16) ? 1 : 0;
        for (int i = 0; i < 16 && bad == 0; i++) if (w2[i] !== exp_q2[i] || w4[i] !== exp_q4[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_data got sizes %0d/%0d want 16/16 in order", w2.size(), w4.size()); end
        en2 = 1'b0; en4 = 1'b0;
        drive();
    endtask

    task automatic test_backpressure();
        int reads, bad;
        logic [DW-1:0] b;
        trace.delete(); got1.delete(); exp_q1.delete();
        for (int i = 0; i < 5; i++) begin b = 8'($urandom_range(0, 255)); q1.push_back(b); exp_q1.push_back(b); end
        rdy1 = 1'b0;
        drive();
        repeat (8) tick();
        reads = 0; bad = 0;
        for (int i = 0; i < 8; i++) if (trace[i].re && trace[i].adr == 2'd0) reads++;
        for (int i = 1; i < 8; i++) if (!trace[i].t1v || trace[i].t1d !== exp_q1[0]) bad++;
        checks++; if (reads != 2) begin errors++; $display("FAIL bp_reads got=%0d want=2", reads); end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got=%0d unstable cycles want=0 (head %h)", bad, exp_q1[0]); end
        rdy1 = 1'b1;
        drive();
        repeat (12) tick();
        bad = (got1.size() != 5) ? 1 : 0;
        for (int i = 0; i < 5 && bad == 0; i++) if (got1[i] !== exp_q1[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_drain got %0d bytes want 5 in order", got1.size()); end
    endtask

    task automatic test_full_flag();
        int bad;
        trace.delete(); w4.delete();
        ovf4 = 1'b1; src4 = '{8'hA5}; en4 = 1'b1;
        drive();
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < 3; i++) if (trace[i].we || trace[i].r4r) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL full_blocked got=%0d writes want=0", bad); end
        ovf4 = 1'b0;
        drive();
        tick();
        checks++;
        if (!(trace[3].we && trace[3].adr == 2'd3 && trace[3].r4r && trace[3].dat == 8'hA5)) begin
            errors++; $display("FAIL full_release got we=%0b adr=%0d rdy=%0b dat=%h want 1/3/1/a5", trace[3].we, trace[3].adr, trace[3].r4r, trace[3].dat);
        end
        en4 = 1'b0;
        drive();
    endtask

    task automatic test_reset_mid_burst();
        int guard, sz;
        logic hit;
        trace.delete();
        for (int i = 0; i < 6; i++) q1.push_back(8'(i + 8'h40));
        for (int i = 0; i < 10; i++) q3.push_back(8'(i + 8'h80));
        rdy1 = 1'b1; rdy3 = 1'b1;
        drive();
        hit = 1'b0; guard = 0;
        while (!hit && guard < 30) begin
            tick(); guard++; sz = trace.size();
            if (sz >= 2) hit = trace[sz-1].re && trace[sz-1].adr == 2'd2 && trace[sz-2].re && trace[sz-2].adr == 2'd2;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_burst_setup got no ch3 burst within %0d cycles", guard); end
        rst = 1'b0;
        #2;
        checks++; if ({sd_re_o, sd_we_o} !== 2'b00) begin errors++; $display("FAIL rst_strobes got=%b want=00", {sd_re_o, sd_we_o}); end
        checks++; if (tx3_valid !== 1'b0) begin errors++; $display("FAIL rst_tx3v got=%0b want=0", tx3_valid); end
        checks++; if (stat_cnt !== 64'd0) begin errors++; $display("FAIL rst_stat got=%h want=0", stat_cnt); end
        for (int c = 0; c < 4; c++) acc[c] = 0;
        @(negedge sd_clk);
        rst = 1'b1;
        drive();
        trace.delete();
        tick();
        checks++;
        if (!(trace[0].re && trace[0].adr == 2'd0)) begin errors++; $display("FAIL rst_first_grant got re=%0b adr=%0d want re=1 adr=0", trace[0].re, trace[0].adr); end
        repeat (25) tick();
        q1.delete(); q3.delete();
        drive();
        got1.delete(); got3.delete();
    endtask

    task automatic test_random();
        int n1, n3, n2, n4, bad;
        logic [DW-1:0] b;
        logic [63:0] exp_stat;
        exp_q1.delete(); exp_q3.delete(); exp_q2.delete(); exp_q4.delete();
        got1.delete(); got3.delete(); w2.delete(); w4.delete();
        viol = 0; n1 = 0; n3 = 0; n2 = 0; n4 = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (n1 < 40 && $urandom_range(0, 2) == 0) begin b = 8'($urandom_range(0, 255)); q1.push_back(b); exp_q1.push_back(b); n1++; end
            if (n3 < 40 && $urandom_range(0, 2) == 0) begin b = 8'($urandom_range(0, 255)); q3.push_back(b); exp_q3.push_back(b); n3++; end
            if (n2 < 40 && $urandom_range(0, 2) == 0) begin b = 8'($urandom_range(0, 255)); src2.push_back(b); exp_q2.push_back(b); n2++; end
            if (n4 < 40 && $urandom_range(0, 2) == 0) begin b = 8'($urandom_range(0, 255)); src4.push_back(b); exp_q4.push_back(b); n4++; end
            rdy1 = ($urandom_range(0, 3) != 0); rdy3 = ($urandom_range(0, 3) != 0);
            en2  = ($urandom_range(0, 4) != 0); en4  = ($urandom_range(0, 4) != 0);
            ovf2 = ($urandom_range(0, 5) == 0); ovf4 = ($urandom_range(0, 5) == 0);
            drive();
            tick();
        end
        rdy1 = 1'b1; rdy3 = 1'b1; en2 = 1'b1; en4 = 1'b1; ovf2 = 1'b0; ovf4 = 1'b0;
        drive();
        repeat (250) tick();
        checks++; if (viol != 0) begin errors++; $display("FAIL rand_protocol got=%0d violations want=0", viol); end
        bad = (got1.size() != exp_q1.size()) ? 1 : 0;
        for (int i = 0; i < got1.size() && bad == 0; i++) if (got1[i] !== exp_q1[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_tx1 got %0d bytes want %0d in order", got1.size(), exp_q1.size()); end
        bad = (got3.size() != exp_q3.size()) ? 1 : 0;
        for (int i = 0; i < got3.size() && bad == 0; i++) if (got3[i] !== exp_q3[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_tx3 got %0d bytes want %0d in order", got3.size(), exp_q3.size()); end
        bad = (w2.size() != exp_q2.size()) ? 1 : 0;
        for (int i = 0; i < w2.size() && bad == 0; i++) if (w2[i] !== exp_q2[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_rx2 got %0d bytes want %0d in order", w2.size(), exp_q2.size()); end
        bad = (w4.size() != exp_q4.size()) ? 1 : 0;
        for (int i = 0; i < w4.size() && bad == 0; i++) if (w4[i] !== exp_q4[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_rx4 got %0d bytes want %0d in order", w4.size(), exp_q4.size()); end
`ifdef SD_FIFO_SCHED_STAT_EN
        exp_stat = {16'(acc[3]), 16'(acc[2]), 16'(acc[1]), 16'(acc[0])};
`else
        exp_stat = 64'd0;
`endif
        checks++; if (stat_cnt !== exp_stat) begin errors++; $display("FAIL rand_stat got=%h want=%h", stat_cnt, exp_stat); end
    endtask

`ifdef SD_FIFO_SCHED_STAT_EN
    task automatic test_stat_wrap();
        rst = 1'b0;
        @(negedge sd_clk);
        rst = 1'b1;
        en4 = 1'b0; q1.delete(); q3.delete(); src4.delete(); w2.delete(); trace.delete();
        for (int i = 0; i < 70000; i++) src2.push_back(8'(i));
        en2 = 1'b1;
        drive();
        repeat (70004) tick();
        checks++; if (w2.size() != 70000) begin errors++; $display("FAIL stat_writes got=%0d want=70000", w2.size()); end
        checks++; if (stat_cnt[31:16] !== 16'd4464) begin errors++; $display("FAIL stat_wrap got=%0d want=4464", stat_cnt[31:16]); end
        trace.delete();
    endtask
`endif

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; sd_dat_i = '0; viol = 0;
        en2 = 1'b0; en4 = 1'b0; rdy1 = 1'b0; rdy3 = 1'b0; ovf2 = 1'b0; ovf4 = 1'b0;
        for (int c = 0; c < 4; c++) acc[c] = 0;
        drive();
        @(negedge sd_clk);
        test_reset();
        test_stream_read();
        test_back_to_back();
        test_backpressure();
        test_full_flag();
        test_reset_mid_burst();
        test_random();
`ifdef SD_FIFO_SCHED_STAT_EN
        test_stat_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
